// File: rtl/frame_pkg.sv
// Shared types and constants for the 32-bit framed receiver: FSM states,
// byte-request codes and the even-parity helper.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    WAIT,
    SAMPLE,
    DONE,
    WAIT_LOW
  } state_t;

  localparam logic [1:0] NXT_B0 = 2'b00;
  localparam logic [1:0] NXT_B1 = 2'b01;
  localparam logic [1:0] NXT_B2 = 2'b10;
  localparam logic [1:0] NXT_B3 = 2'b11;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic even_parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/strobe_gap_counter.sv
// 4-bit gap counter that only moves on b strobes; flags the last gap count
// so the FSM knows the bus has settled and can be sampled.
module strobe_gap_counter #(
  parameter int unsigned SAMPLE_GAP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count,
  output logic       last
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (b) begin
      if (clear)    count <= '0;
      else if (inc) count <= count + 4'd1;
    end
  end

  assign last = (count == 4'(SAMPLE_GAP - 1));

endmodule

// File: rtl/frame_receiver_32.sv
// Receives four {byte,parity} frames over the shared 9-bit bus, checks even
// parity per byte and presents the reassembled word with a one-cycle valid.
module frame_receiver_32
  import frame_pkg::*;
#(
  parameter int unsigned SAMPLE_GAP = 8,
  parameter int unsigned WORD_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b,
  input  logic              ready,
  input  logic [8:0]        in_bus_9,
  output logic              ack,
  output logic [1:0]        nxt_data,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic [3:0]        err_mask,
  output logic              busy
);

  state_t            state;
  logic [1:0]        idx;
  logic [1:0]        byte_sel;
  logic [WORD_W-1:0] staging;
  logic [3:0]        err_stage;
  logic [3:0]        gap;
  logic              gap_last;
  logic              abort;

  strobe_gap_counter #(.SAMPLE_GAP(SAMPLE_GAP)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .b     (b),
    .clear ((state == ACK) || (state == SAMPLE)),
    .inc   (state == WAIT),
    .count (gap),
    .last  (gap_last)
  );

  // Byte 0 lands in the top lane, so the lane index counts down as idx counts up.
  assign byte_sel = 2'd3 - idx;
  assign abort    = !ready && (state inside {ACK, WAIT, SAMPLE});
  assign busy     = (state != IDLE);

  // NOTE: every register here is state, so all assignments are non-blocking and
  // every one of them, including the staging word, is cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      staging    <= '0;
      err_stage  <= '0;
      ack        <= 1'b0;
      nxt_data   <= NXT_B0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      err_mask   <= '0;
    end else begin
      data_valid <= 1'b0;
      if (b) begin
        if (abort) begin
          ack      <= 1'b0;
          nxt_data <= NXT_B0;
          state    <= IDLE;
        end else begin
          unique case (state)
            IDLE: begin
              ack      <= 1'b0;
              nxt_data <= NXT_B0;
              if (ready) state <= ACK;
            end
            ACK: begin
              ack       <= 1'b1;
              idx       <= '0;
              err_stage <= '0;
              state     <= WAIT;
            end
            WAIT: begin
              if (gap_last) state <= SAMPLE;
            end
            SAMPLE: begin
              staging[{byte_sel, 3'b000} +: 8] <= in_bus_9[8:1];
              err_stage[byte_sel] <= even_parity8(in_bus_9[8:1]) != in_bus_9[0];
              if (idx != 2'(BYTES_PER_WORD - 1)) begin
                nxt_data <= idx + 2'd1;
                idx      <= idx + 2'd1;
                state    <= WAIT;
              end else begin
                state <= DONE;
              end
            end
            DONE: begin
              data_out   <= staging;
              err_mask   <= err_stage;
              parity_err <= |err_stage;
              data_valid <= 1'b1;
              ack        <= 1'b0;
              nxt_data   <= NXT_B0;
              // A transmitter still holding ready must drop it before the next word.
              state      <= ready ? WAIT_LOW : IDLE;
            end
            WAIT_LOW: begin
              if (!ready) state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver_32.sv
// Scoreboard bench for frame_receiver_32: a transmitter model serves bytes on
// request, the stimulus queues expected words and a monitor checks each valid.
module tb_frame_receiver_32;

  localparam int SG = 8;

  logic        clk;
  logic        rst;
  logic        b;
  logic        ready;
  logic [8:0]  in_bus_9;
  logic        ack;
  logic [1:0]  nxt_data;
  logic [31:0] data_out;
  logic        data_valid;
  logic        parity_err;
  logic [3:0]  err_mask;
  logic        busy;

  frame_receiver_32 #(.SAMPLE_GAP(SG), .WORD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .b          (b),
    .ready      (ready),
    .in_bus_9   (in_bus_9),
    .ack        (ack),
    .nxt_data   (nxt_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .err_mask   (err_mask),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] word;
    logic [3:0]  mask;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  int          b_period = 1;
  logic [31:0] cur_word = '0;
  logic [3:0]  cur_bad  = '0;
  logic [31:0] last_word = '0;
  logic [3:0]  last_mask = '0;
  logic [7:0]  cur_byte;
  logic        prev_valid = 1'b0;
  logic [1:0]  prev_nxt   = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  // Strobe generator: b high on every b_period-th clock.
  initial begin
    int cyc = 0;
    b = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      b = (cyc % b_period) == 0;
    end
  end

  // Transmitter model: the requested byte (MSB first) with even parity, optionally corrupted.
  always_comb begin
    cur_byte = 8'(cur_word >> (8 * (3 - int'(nxt_data))));
    in_bus_9 = {cur_byte, (^cur_byte) ^ cur_bad[3 - int'(nxt_data)]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: every valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid) begin
        check("valid_width", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(data_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", data_out, e.word);
          check("err_mask", 32'(err_mask), 32'(e.mask));
          check("parity_err", 32'(parity_err), 32'(|e.mask));
        end
      end
      if (nxt_data != prev_nxt)
        check("nxt_order", 32'(nxt_data), (nxt_data == 2'b00) ? 32'd0 : 32'(prev_nxt + 2'd1));
    end
    prev_valid <= data_valid;
    prev_nxt   <= nxt_data;
  end

  task automatic wait_strobe();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (b) break;
    end
    #1;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic [3:0] bad, input bit check_lat);
    int n = 0;
    bit got = 1'b0;
    exp_t e;
    @(negedge clk);
    cur_word = w;
    cur_bad  = bad;
    e.word = w;
    e.mask = bad;
    exp_q.push_back(e);
    ready = 1'b1;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge clk);
      if (b) n++;
      #1;
      got = data_valid;
    end
    if (!got) check("valid_timeout", 32'(data_valid), 32'd1);
    // Detecting strobe, ACK, four (gap + sample) slots, then DONE.
    else if (check_lat) check("latency_strobes", 32'(n), 32'(1 + 1 + 4 * (SG + 1) + 1));
    last_word = w;
    last_mask = bad;
    @(negedge clk);
    ready = 1'b0;
    wait_strobe();
    check("idle_after_ready_low", 32'(busy), 32'd0);
  endtask

  task automatic abort_frame(input logic [31:0] w, input logic [1:0] code);
    bit hit = 1'b0;
    @(negedge clk);
    cur_word = w;
    cur_bad  = '0;
    ready    = 1'b1;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      hit = (nxt_data == code);
    end
    if (!hit) check("nxt_wait_timeout", 32'(nxt_data), 32'(code));
    ready = 1'b0;
    wait_strobe();
    wait_strobe();
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_nxt", 32'(nxt_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_kept", data_out, last_word);
    check("abort_mask_kept", 32'(err_mask), 32'(last_mask));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data_out"}, data_out, 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_nxt"}, 32'(nxt_data), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_perr"}, 32'(parity_err), 32'd0);
    check({tag, "_mask"}, 32'(err_mask), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit hit;
    rst   = 1'b0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b1;

    // Clean frame, corrupted byte 2, then sparse strobes.
    send_frame(32'hA5C30F81, 4'b0000, 1'b1);
    send_frame(32'hA5C30F81, 4'b0010, 1'b1);
    b_period = 3;
    send_frame(32'hA5C30F81, 4'b0000, 1'b1);
    b_period = 1;

    // Abort once byte 0 has been taken.
    abort_frame(32'h11223344, 2'b01);

    // Async reset between edges while waiting on byte 2.
    @(negedge clk);
    cur_word = 32'hCAFEF00D;
    cur_bad  = '0;
    ready    = 1'b1;
    hit      = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      hit = (nxt_data == 2'b10);
    end
    if (!hit) check("reset_wait_timeout", 32'(nxt_data), 32'd2);
    #3 rst = 1'b0;
    #1 check_cleared("midreset");
    ready = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    last_word = '0;
    last_mask = '0;
    send_frame(32'h12345678, 4'b0000, 1'b1);

    // Back-to-back words with ready low for a single strobe between them.
    send_frame(32'hDEADBEEF, 4'b0000, 1'b0);
    send_frame(32'h00000000, 4'b0000, 1'b0);

    // Random words, parity faults and strobe rates.
    for (int k = 0; k < 12; k++) begin
      b_period = $urandom_range(1, 3);
      send_frame($urandom, 4'($urandom_range(0, 15)), 1'b1);
    end
    b_period = 1;

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
